// File: rtl/mem_bus_responder.sv
// Snooping-bus memory responder: 16x16 storage with fixed-latency read responses, abort and write-back handling.
// Optional statistics outputs (rd_count, abort_count) are enabled by defining MEM_RESP_STATS_EN.
module mem_bus_responder #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter logic [15:0] INIT_VALUE  = 16'h0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        bus_valid,
  input  logic [21:0] bus_msg,
  output logic        bus_ready,
  input  logic        abortMem,
  input  logic        dataWB,
  output logic        resp_valid,
  output logic [21:0] resp_msg
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [7:0]  rd_count,
  output logic [7:0]  abort_count
`endif
);

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_WB   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2,
    WB      = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_s;
  logic [1:0]  op_r;
  logic [3:0]  addr_r;
  logic [15:0] mem_r [16];
  logic        bus_ready_r;
  logic        resp_valid_r;
  logic [21:0] resp_msg_r;

  logic        accept_s;
  logic        abort_s;
  logic        wr_en_s;
  logic [3:0]  wr_addr_s;
  logic [15:0] wr_data_s;
  logic [15:0] rd_word_s;
  logic [1:0]  msg_op_s;

  assign msg_op_s  = bus_msg[21:20];
  assign wr_addr_s = bus_msg[19:16];
  assign wr_data_s = bus_msg[15:0];

  // Next-state, counter and memory-write decode
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    abort_s  = 1'b0;
    wr_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (dataWB) begin
          wr_en_s = 1'b1;
        end else if (bus_valid && (msg_op_s != OP_NONE)) begin
          accept_s = 1'b1;
          if (msg_op_s == OP_WB) begin
            wr_en_s = 1'b1;
            state_s = WB;
          end else begin
            cnt_s   = LAT;
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        wr_en_s = dataWB;
        // An abort always beats the response, even on the final wait cycle
        if (abortMem) begin
          abort_s = 1'b1;
          cnt_s   = 4'd0;
          state_s = IDLE;
        end else if (cnt_r <= 4'd1) begin
          cnt_s   = 4'd0;
          state_s = RESPOND;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESPOND: begin
        state_s = IDLE;
      end
      WB: begin
        state_s = IDLE;
      end
      default: begin
        cnt_s   = 4'd0;
        state_s = IDLE;
      end
    endcase
  end

  // Response word forwards a same-cycle snooper write to the pending address
  always_comb begin
    if (wr_en_s && (wr_addr_s == addr_r)) begin
      rd_word_s = wr_data_s;
    end else begin
      rd_word_s = mem_r[addr_r];
    end
  end

  // FSM state, wait counter and latched request
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      op_r    <= 2'b00;
      addr_r  <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        op_r   <= msg_op_s;
        addr_r <= wr_addr_s;
      end
    end
  end

  // Memory array
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) begin
        mem_r[i] <= INIT_VALUE;
      end
    end else if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Registered bus outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_msg_r   <= 22'd0;
    end else begin
      bus_ready_r  <= (state_s == IDLE);
      resp_valid_r <= (state_s == RESPOND);
      if (state_s == RESPOND) begin
        resp_msg_r <= {op_r, addr_r, rd_word_s};
      end
    end
  end

  assign bus_ready  = bus_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_msg   = resp_msg_r;

`ifdef MEM_RESP_STATS_EN
  logic [7:0] rd_count_r;
  logic [7:0] abort_count_r;

  // Saturating response and abort counters
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_count_r    <= 8'd0;
      abort_count_r <= 8'd0;
    end else begin
      if ((state_s == RESPOND) && (rd_count_r != 8'hFF)) begin
        rd_count_r <= rd_count_r + 8'd1;
      end
      if (abort_s && (abort_count_r != 8'hFF)) begin
        abort_count_r <= abort_count_r + 8'd1;
      end
    end
  end

  assign rd_count    = rd_count_r;
  assign abort_count = abort_count_r;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed vector table, reset-mid-WAIT sequence,
// randomized traffic against a transaction-level model, and a long back-to-back read run.
module tb_mem_bus_responder;

  localparam int          LAT  = 2;
  localparam logic [15:0] INIT = 16'h0000;

  logic        clock;
  logic        resetn;
  logic        bus_valid;
  logic [21:0] bus_msg;
  logic        bus_ready;
  logic        abortMem;
  logic        dataWB;
  logic        resp_valid;
  logic [21:0] resp_msg;
`ifdef MEM_RESP_STATS_EN
  logic [7:0]  rd_count;
  logic [7:0]  abort_count;
`endif

  mem_bus_responder #(.MEM_LATENCY(LAT), .INIT_VALUE(INIT)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .bus_valid  (bus_valid),
    .bus_msg    (bus_msg),
    .bus_ready  (bus_ready),
    .abortMem   (abortMem),
    .dataWB     (dataWB),
    .resp_valid (resp_valid),
    .resp_msg   (resp_msg)
`ifdef MEM_RESP_STATS_EN
    ,
    .rd_count   (rd_count),
    .abort_count(abort_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: a pending read is due at a known cycle number
  int          ncyc;
  bit          pend;
  logic [1:0]  p_op;
  logic [3:0]  p_addr;
  int          p_due;
  int          wb_cyc;
  logic [15:0] mem_m [16];
  int          rd_exp;
  int          ab_exp;

  typedef struct {
    logic        v;
    logic [21:0] msg;
    logic        ab;
    logic        wb;
    logic        exp_ready;
    logic        exp_valid;
    logic [21:0] exp_msg;
  } vec_t;

  vec_t tab[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, ncyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pend   = 1'b0;
    p_due  = -1;
    wb_cyc = -1;
    rd_exp = 0;
    ab_exp = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = INIT;
  endtask

  // Check outputs of the current cycle against the model, drive this cycle's inputs, advance one clock
  task automatic step(input logic v, input logic [21:0] m, input logic ab, input logic wbi);
    bit exp_ready;
    bit exp_valid;
    bit in_idle;
    bit in_wait;
    exp_ready = !pend && (ncyc != wb_cyc);
    exp_valid = pend && (ncyc == p_due);
    check("bus_ready", 32'(bus_ready), 32'(exp_ready));
    check("resp_valid", 32'(resp_valid), 32'(exp_valid));
    if (exp_valid) check("resp_msg", 32'(resp_msg), 32'({p_op, p_addr, mem_m[p_addr]}));
    if (exp_valid && rd_exp < 255) rd_exp++;
`ifdef MEM_RESP_STATS_EN
    check("rd_count", 32'(rd_count), 32'(rd_exp));
    check("abort_count", 32'(abort_count), 32'(ab_exp));
`endif
    bus_valid = v;
    bus_msg   = m;
    abortMem  = ab;
    dataWB    = wbi;
    in_idle = exp_ready;
    in_wait = pend && (ncyc < p_due);
    if (wbi && (in_idle || in_wait)) begin
      mem_m[m[19:16]] = m[15:0];
    end else if (in_idle && v && m[21:20] != 2'b00) begin
      if (m[21:20] == 2'b11) begin
        mem_m[m[19:16]] = m[15:0];
        wb_cyc = ncyc + 1;
      end else begin
        pend   = 1'b1;
        p_op   = m[21:20];
        p_addr = m[19:16];
        p_due  = ncyc + 1 + LAT;
      end
    end
    if (in_wait && ab) begin
      pend = 1'b0;
      if (ab_exp < 255) ab_exp++;
    end
    if (exp_valid) pend = 1'b0;
    @(posedge clock);
    ncyc++;
    @(negedge clock);
  endtask

  initial begin
    // Directed vectors: expected outputs in cycle i, then cycle i inputs
    tab.push_back('{1'b1, 22'h130000, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 22'h130000});
    tab.push_back('{1'b1, 22'h35BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000000});
    tab.push_back('{1'b1, 22'h150000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b1, 22'h150000, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 22'h15BEEF});
    tab.push_back('{1'b1, 22'h120000, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b1, 22'h270000, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h071234, 1'b0, 1'b1, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 22'h271234});
    tab.push_back('{1'b1, 22'h130000, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000000});
    tab.push_back('{1'b1, 22'h195555, 1'b0, 1'b1, 1'b1, 1'b0, 22'h000000});
    tab.push_back('{1'b1, 22'h190000, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 22'h195555});
    tab.push_back('{1'b1, 22'h290000, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 22'h295555});
    tab.push_back('{1'b1, 22'h030000, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000000});
    tab.push_back('{1'b0, 22'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000000});

    ncyc      = 0;
    resetn    = 1'b0;
    bus_valid = 1'b0;
    bus_msg   = 22'd0;
    abortMem  = 1'b0;
    dataWB    = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check("reset bus_ready", 32'(bus_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_msg", 32'(resp_msg), 32'd0);
    resetn = 1'b1;

    foreach (tab[i]) begin
      check($sformatf("vec%0d ready", i), 32'(bus_ready), 32'(tab[i].exp_ready));
      check($sformatf("vec%0d valid", i), 32'(resp_valid), 32'(tab[i].exp_valid));
      if (tab[i].exp_valid) check($sformatf("vec%0d msg", i), 32'(resp_msg), 32'(tab[i].exp_msg));
      step(tab[i].v, tab[i].msg, tab[i].ab, tab[i].wb);
    end

    // Reset in the middle of WAIT drops the read and restores word 3
    step(1'b1, 22'h33ABCD, 1'b0, 1'b0);
    step(1'b0, 22'h000000, 1'b0, 1'b0);
    step(1'b1, 22'h130000, 1'b0, 1'b0);
    step(1'b0, 22'h000000, 1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    check("midreset bus_ready", 32'(bus_ready), 32'd1);
    check("midreset resp_valid", 32'(resp_valid), 32'd0);
    check("midreset resp_msg", 32'(resp_msg), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 22'h000000, 1'b0, 1'b0);
    step(1'b1, 22'h130000, 1'b0, 1'b0);
    step(1'b0, 22'h000000, 1'b0, 1'b0);
    step(1'b0, 22'h000000, 1'b0, 1'b0);
    check("post-reset read valid", 32'(resp_valid), 32'd1);
    check("post-reset read msg", 32'(resp_msg), 32'h130000);
    step(1'b0, 22'h000000, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 9) < 6), 22'($urandom), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 9) == 0));
    end

    // Long run of held BusRd requests (saturates the response counter when enabled)
    for (int i = 0; i < 1300; i++) begin
      step(1'b1, {2'b01, 4'($urandom_range(0, 15)), 16'h0000}, 1'b0, 1'b0);
    end
`ifdef MEM_RESP_STATS_EN
    check("rd_count saturated", 32'(rd_count), 32'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter MEM_LATENCY, default 2, wait cycles between accept and response; legal 1..15.
REQ-002 Parameter INIT_VALUE, default 16'h0000, reset contents of every memory word.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 bus_valid  input  1  bus message present on bus_msg.
REQ-006 bus_msg  input  22  [21:20] op (00 none, 01 BusRd, 10 BusRdX, 11 WriteBack), [19:16] address, [15:0] data.
REQ-007 bus_ready  output  1  responder can accept a message this cycle.
REQ-008 abortMem  input  1  a snooping cache supplies the line; memory cancels the pending response.
REQ-009 dataWB  input  1  bus_msg carries snooper write-back data this cycle (op field ignored).
REQ-010 resp_valid  output  1  one-cycle response strobe.
REQ-011 resp_msg  output  22  {echoed op, address, data}; meaningful only when resp_valid=1.

Function
REQ-012 Storage SHALL be 16 words x 16 bits, indexed by bus_msg[19:16].
REQ-013 FSM states SHALL be IDLE, WAIT, RESPOND, WB.
REQ-014 Accept SHALL occur when bus_valid=1, bus_ready=1, op!=00; op=00 with bus_valid=1 is ignored.
REQ-015 bus_ready SHALL be 1 in IDLE only.
REQ-016 IDLE, accepted op 01/10: latch op and address, load wait counter with MEM_LATENCY, go WAIT.
REQ-017 IDLE, accepted op 11: write bus_msg[15:0] to addressed word, go WB; WB returns to IDLE next cycle; no response.
REQ-018 WAIT: counter decrements each cycle; at zero go RESPOND.
REQ-019 WAIT, abortMem=1: return to IDLE next cycle, no response, pending op discarded.
REQ-020 abortMem in the same cycle the counter reaches zero SHALL win; no response.
REQ-021 WAIT, dataWB=1: write bus_msg[15:0] to word bus_msg[19:16]; same address as pending SHALL make the response carry the new data.
REQ-022 RESPOND: resp_valid=1 for exactly one cycle, resp_msg={latched op, latched address, current word}; then IDLE.
REQ-023 BusRdX (10) SHALL NOT modify memory; responder never invalidates.
REQ-024 Accept-to-resp_valid latency SHALL be MEM_LATENCY+1 cycles.
REQ-025 dataWB in IDLE SHALL write memory and not count as an accept.
REQ-026 bus_valid outside IDLE SHALL be ignored; the initiator holds the message until bus_ready.

Reset
REQ-027 resetn=0 SHALL immediately force IDLE, bus_ready=1, resp_valid=0, resp_msg=0, wait counter 0, all words=INIT_VALUE.
REQ-028 Reset mid-WAIT or mid-RESPOND SHALL drop the transaction with no response after release.
REQ-029 First accept SHALL be possible on the first rising edge with resetn=1.

Configuration
REQ-030 Macro MEM_RESP_STATS_EN defined: add outputs rd_count[7:0] (responses issued) and abort_count[7:0] (aborted transactions), both saturating at 8'hFF, cleared by reset.
REQ-031 Macro MEM_RESP_STATS_EN undefined: neither port nor counters exist; all other behaviour identical.

Verification
REQ-032 Reset, BusRd addr 4'h3, MEM_LATENCY=2 -> resp_valid 3 cycles after accept, resp_msg=22'h130000.
REQ-033 WriteBack addr 4'h5 data 16'hBEEF, then BusRd addr 4'h5 -> resp_msg=22'h15BEEF; bus_ready low only in WB cycle.
REQ-034 BusRd addr 4'h2, abortMem=1 in first WAIT cycle -> no resp_valid; bus_ready=1 next cycle; abort_count=1 (stats build).
REQ-035 BusRdX addr 4'h7, dataWB with addr 4'h7 data 16'h1234 during WAIT -> resp_msg=22'h271234.
REQ-036 abortMem coincident with counter reaching zero -> no response; resetn=0 during WAIT -> no response after release, word 4'h3 reads INIT_VALUE.
REQ-037 300 back-to-back BusRd transactions (stats build) -> rd_count=8'hFF.
